mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares one single-port synchronous SRAM between the CPU's instruction-fetch stage and its data-memory stage, so one memory image serves both code and data. It sits between the pipeline and the SRAM. It grants at most one access per cycle and tracks which requester owns the outstanding read. It drives per-requester stall signals back to the pipeline.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on all ports
- DATA_W, 32, data width on all ports
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (range 1–15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- if_req  in  1  fetch requests a read
- if_addr  in  ADDR_W  fetch address; held stable until if_gnt
- if_gnt  out  1  fetch access issued to SRAM this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- if_stall  out  1  if_req & ~if_gnt
- d_req  in  1  data stage requests an access
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address; held until d_gnt
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  d_rdata valid (reads only)
- d_rdata  out  DATA_W  data read data
- d_stall  out  1  d_req & ~d_gnt
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, one cycle after mem_en

## Operation
- Grant logic is combinational from the requests and the priority flag. At most one of if_gnt and d_gnt is high in any cycle.
- Default priority: data wins. This prevents deadlock when the data stage stalls the pipeline.
- When both requests are high:
  - d_gnt goes high, unless starve_flag is set.
  - If starve_flag is set, if_gnt goes high instead.
- On a grant, the selected address, we and wdata are muxed to the SRAM with mem_en=1. For a fetch grant, mem_we=0.
- No grant: mem_en=0, and mem_addr, mem_wdata and mem_we are driven 0.
- Owner FSM, a registered state recording the access issued in the previous cycle:
  - States: IDLE, IF_RD, D_RD, D_WR.
  - Next state is set by this cycle's grant type. With no grant, next state is IDLE.
- Read return:
  - In state IF_RD: if_rvalid=1 and if_rdata=mem_rdata.
  - In state D_RD: d_rvalid=1 and d_rdata=mem_rdata.
  - The rdata port of the other requester is driven 0.
  - D_WR and IDLE produce no rvalid.
- Starvation counter, 4 bits:
  - Increments each cycle that if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - Clears on if_gnt or when if_req=0.
  - starve_flag = (count == STARVE_MAX).
- Back-to-back: a requester holding req high with a new address after a grant may be granted in consecutive cycles, giving one access per cycle.
- Write-then-read to the same address in consecutive cycles returns the new data. The SRAM commits the write at the edge.

## Timing
- Reset values: state=IDLE, counter=0, all outputs 0.
- Reset asserted mid-operation discards a pending read. No rvalid is produced after rst_n is released.
- Grant latency: 0 cycles, combinational in the request cycle. Read data latency: 1 cycle after the grant.
- Worst-case fetch wait with the starvation guard compiled in: STARVE_MAX cycles under continuous d_req.
- Critical path: req → grant → mem_addr mux.

## Configuration
- MEM_ARB_STARVE_EN defined: the starvation counter and starve_flag are present, with behaviour as above.
- MEM_ARB_STARVE_EN undefined:
  - Strict data priority; fetch can be starved indefinitely.
  - The counter is not instantiated and starve_flag is tied 0.
  - STARVE_MAX is ignored.

## Structure
- Shared package mem_arb_pkg holds:
  - The owner-state enum (IDLE, IF_RD, D_RD, D_WR), 2 bits.
  - The constant for the counter width (4).
- One sub-module, arb_starve_ctr: the saturating counter plus flag compare. It is instantiated only under MEM_ARB_STARVE_EN.

## Test plan
- Fetch only: if_req=1, if_addr=0x10, SRAM[0x10]=0xDEADBEEF → if_gnt in the same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Collision: if_req=d_req=1, d_we=0, d_addr=0x40 → d_gnt=1, if_stall=1, mem_addr=0x40; d_rvalid the next cycle.
- Write-then-read: d write 0x20←0x12345678, then d read 0x20 on the next cycle → d_rdata=0x12345678 two cycles after the write grant.
- Starvation with MEM_ARB_STARVE_EN, STARVE_MAX=4: d_req and if_req held high continuously.
  - Expected: if_gnt in cycle 5, then the counter clears.
  - Without the macro: no if_gnt in 20 cycles.
- Reset mid-read: grant d read, then pull rst_n low before the next edge → d_rvalid stays 0, all outputs 0, state IDLE after release.
- Idle: no requests for 10 cycles → mem_en=0, no grants, counter 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data SRAM arbiter: owner-state encoding
// and the starvation counter width.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arbiter_starve.sv
// arb_starve_ctr: saturating count of consecutive denied fetch cycles;
// starve_flag forces the next fetch/data collision in favour of fetch.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    output logic starve_flag
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!if_req || if_gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve_flag = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous SRAM between instruction
// fetch and the data stage. Optional fetch starvation guard: MEM_ARB_STARVE_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_arbiter: STARVE_MAX must be in 1..15");
    end

    logic   starve_flag;
    owner_t owner_q, owner_d;

`ifdef MEM_ARB_STARVE_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_gnt      (if_gnt),
        .starve_flag (starve_flag)
    );
`else
    assign starve_flag = 1'b0;
`endif

    // Data wins by default so a data-stage stall can never deadlock the pipe;
    // grants are held off while in reset so every output reads 0 there.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (d_req && !(if_req && starve_flag)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign if_stall = rst_n & if_req & ~if_gnt;
    assign d_stall  = rst_n & d_req & ~d_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    always_comb begin
        owner_d = IDLE;
        if (if_gnt) begin
            owner_d = IF_RD;
        end else if (d_gnt) begin
            owner_d = d_we ? D_WR : D_RD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // The read returning this cycle belongs to whoever was granted last cycle.
    assign if_rvalid = (owner_q == IF_RD);
    assign d_rvalid  = (owner_q == D_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
